// File: rtl/mdp3_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdp3_pkg
//  Description : Shared MDP3 entry types, message constants and byteswap
//                helpers used by the entry serializer and parser.
//  Revision    : 1.0
// ============================================================================
package mdp3_pkg;

    typedef enum logic [1:0] {
        ACT_NEW     = 2'd0,
        ACT_CHANGE  = 2'd1,
        ACT_DELETE  = 2'd2,
        ACT_OVERLAY = 2'd3
    } action_t;

    typedef enum logic [1:0] {
        ET_BID           = 2'd0,
        ET_OFFER         = 2'd1,
        ET_IMPLIED_BID   = 2'd2,
        ET_IMPLIED_OFFER = 2'd3
    } entry_type_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    typedef struct packed {
        action_t     action;
        entry_type_t etype;
        logic [31:0] sid;
        logic [63:0] price;
        logic [15:0] qty;
        logic [7:0]  norders;
    } entry_t;

    localparam int          MDP3_BEATS_PER_ENTRY = 5;
    localparam logic [15:0] MDP3_MSG_SIZE        = 16'd40;
    localparam logic [15:0] MDP3_TEMPLATE_BOOK   = 16'd46;

    // Field positions inside the beats that carry sub-word fields
    localparam int B1_ACTION_LSB = 24;
    localparam int B1_TYPE_LSB   = 16;
    localparam int B4_NORD_LSB   = 56;

    function automatic logic [15:0] bswap16(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [63:0] bswap64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*i +: 8] = d[8*(7-i) +: 8];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdp3_entry_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mdp3_entry_serializer_if
//  Description : Entry handshake plus FIFO write-side bus of the serializer.
//  Revision    : 1.0
// ============================================================================
interface mdp3_entry_serializer_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ACTION;
    logic [1:0]  ENTRY_TYPE;
    logic [31:0] SECURITY_ID;
    logic [63:0] PRICE;
    logic [15:0] QUANTITY;
    logic [7:0]  NUM_ORDERS;
    logic        fifo_full;
    logic        out_wr;
    logic [63:0] out_data;

    modport master (
        output in_valid, ACTION, ENTRY_TYPE, SECURITY_ID, PRICE, QUANTITY,
               NUM_ORDERS, fifo_full,
        input  in_ready, out_wr, out_data
    );

    modport slave (
        input  in_valid, ACTION, ENTRY_TYPE, SECURITY_ID, PRICE, QUANTITY,
               NUM_ORDERS, fifo_full,
        output in_ready, out_wr, out_data
    );
endinterface
`default_nettype wire

// File: rtl/mdp3_entry_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : mdp3_entry_serializer
//  Description : Packs one book-update entry into a 5-beat little-endian
//                MDP3 message and writes it into a back-pressured FIFO.
//  Revision    : 1.0
// ============================================================================
module mdp3_entry_serializer
    import mdp3_pkg::*;
#(
    parameter logic [15:0] TEMPLATE_ID = MDP3_TEMPLATE_BOOK,
    parameter logic [31:0] SEQ_INIT    = 32'd1
) (
    input  wire logic              clk,
    input  wire logic              reset,
    mdp3_entry_serializer_if.slave bus,
    output      logic              busy,
    output      logic [31:0]       seq_num
);

    localparam logic [2:0] c_LAST_BEAT = 3'(MDP3_BEATS_PER_ENTRY - 1);

    ser_state_t  r_state;
    logic [2:0]  r_beat_idx;
    entry_t      r_entry;
    logic [31:0] r_seq;

    logic        w_send;
    logic        w_last;
    logic        w_out_wr;
    logic        w_in_ready;
    logic        w_accept;

    function automatic logic [63:0] beat_mux(input logic [2:0]  idx,
                                             input entry_t      e,
                                             input logic [31:0] seq);
        logic [63:0] r;
        logic [31:0] s;
        logic [63:0] p;
        r = '0;
        s = bswap32(e.sid);
        p = bswap64(e.price);
        case (idx)
            3'd0: r = {bswap32(seq), bswap16(MDP3_MSG_SIZE), bswap16(TEMPLATE_ID)};
            3'd1: begin
                r[B1_ACTION_LSB +: 2] = e.action;
                r[B1_TYPE_LSB   +: 2] = e.etype;
                r[15:0]               = s[31:16];
            end
            3'd2: begin
                r[63:48] = s[15:0];
                r[15:0]  = p[63:48];
            end
            3'd3: r = {p[47:0], bswap16(e.qty)};
            3'd4: r[B4_NORD_LSB +: 8] = e.norders;
            default: r = '0;
        endcase
        return r;
    endfunction

    assign w_send   = (r_state == ST_SEND);
    assign w_last   = (r_beat_idx == c_LAST_BEAT);
    // Gated by reset so an abandoned message never leaks a beat in the reset cycle
    assign w_out_wr   = w_send & ~bus.fifo_full & ~reset;
    assign w_in_ready = ~reset & (~w_send | (w_last & ~bus.fifo_full));
    assign w_accept   = bus.in_valid & w_in_ready;

    assign bus.out_wr   = w_out_wr;
    assign bus.in_ready = w_in_ready;
    assign bus.out_data = w_send ? beat_mux(r_beat_idx, r_entry, r_seq) : 64'd0;
    assign busy         = w_send;
    assign seq_num      = r_seq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_beat_idx <= 3'd0;
            r_entry    <= '0;
            r_seq      <= SEQ_INIT;
        end else begin
            if (w_out_wr) begin
                if (w_last) begin
                    r_seq      <= r_seq + 32'd1;
                    r_state    <= ST_IDLE;
                    r_beat_idx <= 3'd0;
                end else begin
                    r_beat_idx <= r_beat_idx + 3'd1;
                end
            end
            // A same-cycle accept overrides the return to IDLE (back-to-back)
            if (w_accept) begin
                r_entry.action  <= action_t'(bus.ACTION);
                r_entry.etype   <= entry_type_t'(bus.ENTRY_TYPE);
                r_entry.sid     <= bus.SECURITY_ID;
                r_entry.price   <= bus.PRICE;
                r_entry.qty     <= bus.QUANTITY;
                r_entry.norders <= bus.NUM_ORDERS;
                r_state         <= ST_SEND;
                r_beat_idx      <= 3'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/mdp3_entry_serializer.md
Name: mdp3_entry_serializer

Overview:
Transmit-side counterpart of the MDP3 64-bit-beat entry parser.
- Accepts one decoded book-update entry per handshake: action, entry type, security ID, price, quantity, num orders.
- Packs the entry into a 5-beat little-endian MDP3 message and writes it into the parser-side input FIFO, honouring FIFO back-pressure.
- Used as the outbound encoder and as the loopback stimulus source for the parser.

Parameters:
TEMPLATE_ID, 16'd46, SBE template ID written into the header beat.
SEQ_INIT, 32'd1, sequence number of the first message after reset.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  entry fields valid.
in_ready  output  1  serializer can accept an entry this cycle.
ACTION  input  2  entry action.
ENTRY_TYPE  input  2  entry type.
SECURITY_ID  input  32  security ID.
PRICE  input  64  price.
QUANTITY  input  16  quantity.
NUM_ORDERS  input  8  order count.
fifo_full  input  1  downstream FIFO cannot accept a write.
out_wr  output  1  write strobe; one beat is transferred per cycle with out_wr=1.
out_data  output  64  beat payload.
busy  output  1  message in progress.
seq_num  output  32  sequence number of the next message to be emitted.

Behaviour:
- States: IDLE and SEND. SEND uses beat counter beat_idx from 0 to 4.
- Reset values: state=IDLE, beat_idx=0, seq_num=SEQ_INIT, busy=0, out_wr=0, out_data=0. Entry register clears to 0.
- Combinational outputs:
  - in_ready = (IDLE) | (SEND & beat_idx==4 & !fifo_full).
  - out_wr = SEND & !fifo_full.
  - busy = SEND.
  - out_data = beat mux of the entry register when in SEND, else 0.
- Accept: when in_valid & in_ready, capture all fields into the entry register at the edge, then enter (or stay in) SEND with beat_idx=0.
- Beat advance: only on cycles where out_wr=1.
  - When fifo_full=1, the beat and out_data hold unchanged (no write lost or duplicated).
- After beat 4 is written:
  - seq_num increments mod 2^32 (wraps from FFFFFFFF to 0).
  - If an entry is accepted in the same cycle, go back-to-back: next cycle beat_idx=0 with the new entry. Otherwise return to IDLE.
- Latency: first beat is presented the cycle after acceptance. With no stalls, one message takes exactly 5 consecutive write cycles, giving a sustained rate of 1 entry per 5 cycles.
- Beat layout (bytes LE; unlisted bits are 0):
  - b0: [63:32]=byteswap32(seq_num); [31:16]=16'h2800 (msg size 40 LE); [15:0]=byteswap16(TEMPLATE_ID).
  - b1: [25:24]=ACTION; [17:16]=ENTRY_TYPE; [15:8]=SID[7:0]; [7:0]=SID[15:8].
  - b2: [63:56]=SID[23:16]; [55:48]=SID[31:24]; [15:8]=PRICE[7:0]; [7:0]=PRICE[15:8].
  - b3: [63:16]= PRICE bytes 2..7 in LE order ([63:56]=PRICE[23:16], …, [23:16]=PRICE[63:56]); [15:8]=QTY[7:0]; [7:0]=QTY[15:8].
  - b4: [63:56]=NUM_ORDERS.
- Input fields are sampled only at acceptance; changes to them during SEND have no effect.
- Reset asserted mid-message: the message is abandoned. out_wr is 0 from the reset cycle on, and seq_num returns to SEQ_INIT. No partial message is completed.
- in_valid while not ready: ignored. The source must hold the entry until in_ready.
- fifo_full asserted exactly on beat 4: in_ready=0 that cycle. The back-to-back accept waits until the write completes.

Decomposition:
Shared package mdp3_pkg holds:
- action_t (2b) and entry_type_t (2b).
- MDP3_BEATS_PER_ENTRY=5, MDP3_MSG_SIZE=16'd40, MDP3_TEMPLATE_BOOK=16'd46.
- Beat bit-position constants.
- Byteswap16/32/64 functions, shared with the parser.

No sub-module: a single FSM plus a beat-mux function.

Test Plan:
- Single entry, SEQ_INIT=1, ACTION=1, ENTRY_TYPE=2, SID=32'h11223344, PRICE=64'h0102030405060708, QTY=16'hAABB, NUM_ORDERS=8'h05, fifo_full=0 -> 5 consecutive writes:
  - 64'h01000000_28002E00
  - 64'h00000000_01024433
  - 64'h22110000_00000807
  - 64'h06050403_0201BBAA
  - 64'h05000000_00000000
  - After the last write, seq_num=2.
- Back-to-back: in_valid held high with two entries -> 10 contiguous out_wr cycles with no gap. Header seq fields are 32'h01000000 then 32'h02000000.
- Back-pressure: fifo_full=1 for 3 cycles during beat 2 -> out_data stays at the b2 value, out_wr=0 for those cycles, exactly 5 writes total with identical values.
- Reset during beat 3 -> out_wr=0 from the reset edge on, busy=0, seq_num=1. The next entry starts with header 64'h01000000_28002E00.
- Wrap: SEQ_INIT=32'hFFFFFFFF, two entries -> headers carry 32'hFFFFFFFF then 32'h00000000.
- Loopback into the FIFO→parser chain -> the parser outputs SID, PRICE, QTY and NUM_ORDERS equal to the inputs for 20 random entries.
